// File: rtl/rcn_dma_sched.sv
// Round-robin DMA request scheduler: latches request edges into per-channel
// pending flags, offers one channel at a time to the engine over valid/ready,
// waits for done and acks the requester. A watchdog aborts stuck transfers.
module rcn_dma_sched #(
  parameter int unsigned CHANNELS  = 16,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CHANNELS-1:0]  req,
  input  logic [CHANNELS-1:0]  ch_enable,
  input  logic [TIMEOUT_W-1:0] timeout,
  output logic                 grant_valid,
  output logic [3:0]           grant_ch,
  input  logic                 grant_ready,
  input  logic                 done,
  output logic [CHANNELS-1:0]  ack,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [3:0]           err_ch
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_OFFER  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  localparam logic [4:0]           CH_N    = 5'(CHANNELS);
  localparam logic [3:0]           CH_LAST = 4'(CHANNELS - 1);
  localparam logic [TIMEOUT_W-1:0] TMR_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [CHANNELS-1:0]  OH_ONE  = {{(CHANNELS-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [CHANNELS-1:0]  r_req_q;
  logic [CHANNELS-1:0]  r_pending;
  logic [CHANNELS-1:0]  r_ack;
  logic [3:0]           r_grant_ch;
  logic [3:0]           r_err_ch;
  logic [3:0]           r_last;
  logic                 r_grant_valid;
  logic                 r_timeout_err;
  logic                 r_wd_en;
  logic [TIMEOUT_W-1:0] r_timer;

  logic                 w_accept;
  logic [CHANNELS-1:0]  w_grant_oh;
  logic [CHANNELS-1:0]  w_edge;
  logic [CHANNELS-1:0]  w_acc_clr;
  logic [CHANNELS-1:0]  w_pending_nxt;
  logic                 w_found;
  logic [3:0]           w_pick;
  logic [4:0]           w_idx;

  assign w_accept   = (r_state == S_OFFER) && grant_ready;
  assign w_grant_oh = OH_ONE << r_grant_ch;
  assign w_edge     = req & ~r_req_q & ch_enable;
  assign w_acc_clr  = w_accept ? w_grant_oh : '0;
  // A fresh edge re-arms a channel even in its own accept cycle; disable always wins.
  assign w_pending_nxt = ((r_pending & ~w_acc_clr) | w_edge) & ch_enable;

  // Round-robin search: first pending channel starting at last+1, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_idx = {1'b0, r_last} + 5'd1 + 5'(i);
      if (w_idx >= CH_N) w_idx = w_idx - CH_N;
      if (!w_found && r_pending[w_idx[3:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[3:0];
      end
    end
  end

  // Request edge capture and pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q   <= '0;
      r_pending <= '0;
    end else begin
      r_req_q   <= req;
      r_pending <= w_pending_nxt;
    end
  end

  // Scheduler FSM with grant, completion, and watchdog handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_ch    <= '0;
      r_ack         <= '0;
      r_timeout_err <= 1'b0;
      r_err_ch      <= '0;
      r_last        <= CH_LAST;
      r_timer       <= '0;
      r_wd_en       <= 1'b0;
    end else begin
      r_ack         <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant_ch    <= w_pick;
            r_grant_valid <= 1'b1;
            r_state       <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (grant_ready) begin
            r_grant_valid <= 1'b0;
            r_timer       <= timeout;
            r_wd_en       <= |timeout;
            r_state       <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (done) begin
            r_ack   <= w_grant_oh;
            r_last  <= r_grant_ch;
            r_state <= S_IDLE;
          end else if (r_wd_en) begin
            if (r_timer == TMR_ONE) begin
              r_timeout_err <= 1'b1;
              r_err_ch      <= r_grant_ch;
              r_last        <= r_grant_ch;
              r_state       <= S_IDLE;
            end else begin
              r_timer <= r_timer - TMR_ONE;
            end
          end
        end
        default: begin
          r_grant_valid <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_ch    = r_grant_ch;
  assign ack         = r_ack;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;
  assign err_ch      = r_err_ch;

endmodule

// File: tb/tb_rcn_dma_sched.sv
// Scoreboard bench for rcn_dma_sched: expected grants/acks are queued as
// stimulus is driven and popped by a negedge monitor; scenario tasks also
// check cycle-exact timing inline.
module tb_rcn_dma_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] ch_enable;
  logic [15:0] timeout;
  logic        grant_valid;
  logic [3:0]  grant_ch;
  logic        grant_ready;
  logic        done;
  logic [15:0] ack;
  logic        busy;
  logic        timeout_err;
  logic [3:0]  err_ch;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_grant[$];
  logic [15:0] exp_ack[$];

  rcn_dma_sched #(.CHANNELS(16), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ch_enable(ch_enable),
    .timeout(timeout), .grant_valid(grant_valid), .grant_ch(grant_ch),
    .grant_ready(grant_ready), .done(done), .ack(ack), .busy(busy),
    .timeout_err(timeout_err), .err_ch(err_ch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input bit with_ack);
    logic [15:0] oh;
    exp_grant.push_back(ch);
    oh = 16'h0001 << ch;
    if (with_ack) exp_ack.push_back(oh);
  endtask

  // Serve n offers: accept, then return done dly cycles after each accept.
  task automatic serve(input int n, input int dly, output bit ok);
    ok = 1'b1;
    for (int g = 0; g < n; g++) begin
      int w;
      w = 0;
      while (!(grant_valid === 1'b1 && grant_ready === 1'b1) && w < 50) begin
        tick();
        w++;
      end
      if (w >= 50) begin
        ok = 1'b0;
        return;
      end
      tick();
      repeat (dly - 1) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
    end
  endtask

  task automatic monitor();
    int          e;
    logic [15:0] ea;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (grant_valid === 1'b1 && grant_ready === 1'b1) begin
          n_vec++;
          if (exp_grant.size() == 0) begin
            n_err++;
            $display("FAIL sb_grant got=%0d exp=none", grant_ch);
          end else begin
            e = exp_grant.pop_front();
            if (grant_ch !== 4'(e)) begin
              n_err++;
              $display("FAIL sb_grant got=%0d exp=%0d", grant_ch, e);
            end
          end
        end
        if (ack !== 16'h0) begin
          n_vec++;
          if (exp_ack.size() == 0) begin
            n_err++;
            $display("FAIL sb_ack got=%h exp=none", ack);
          end else begin
            ea = exp_ack.pop_front();
            if (ack !== ea) begin
              n_err++;
              $display("FAIL sb_ack got=%h exp=%h", ack, ea);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0; req = '0; ch_enable = '1; timeout = '0; grant_ready = 1'b1; done = 1'b0;
    repeat (2) tick();
    n_vec++;
    if ({grant_valid, busy, timeout_err} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl got=%b exp=000", {grant_valid, busy, timeout_err});
    end
    n_vec++;
    if ({grant_ch, err_ch, ack} !== 24'h0) begin
      n_err++; $display("FAIL reset_data got=%h exp=000000", {grant_ch, err_ch, ack});
    end
    rst_n = 1'b1;
    req[3] = 1'b1; push(3, 1'b0);
    tick();
    req[3] = 1'b0;
    n_vec++;
    if (grant_valid !== 1'b0) begin n_err++; $display("FAIL early_offer got=%b exp=0", grant_valid); end
    tick();
    n_vec++;
    if ({grant_valid, grant_ch} !== {1'b1, 4'd3}) begin
      n_err++; $display("FAIL offer3 got=%b/%0d exp=1/3", grant_valid, grant_ch);
    end
    tick();
    n_vec++;
    if ({busy, grant_valid} !== 2'b10) begin
      n_err++; $display("FAIL active3 got=%b exp=10", {busy, grant_valid});
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({grant_valid, busy, timeout_err, grant_ch, ack} !== 23'h0) begin
      n_err++; $display("FAIL async_reset got=%h exp=0", {grant_valid, busy, timeout_err, grant_ch, ack});
    end
    tick();
    rst_n = 1'b1;
    req[0] = 1'b1; req[15] = 1'b1;
    push(0, 1'b1); push(15, 1'b1);
    tick();
    req = '0;
    serve(2, 3, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL reset_serve got=timeout exp=2 grants"); end
  endtask

  task automatic test_round_robin();
    bit ok;
    push(1, 1'b1); push(5, 1'b1); push(14, 1'b1);
    req[1] = 1'b1; req[5] = 1'b1; req[14] = 1'b1;
    tick();
    req = '0;
    n_vec++;
    if (grant_valid !== 1'b0) begin n_err++; $display("FAIL rr_latency got=%b exp=0", grant_valid); end
    tick();
    n_vec++;
    if ({grant_valid, grant_ch} !== {1'b1, 4'd1}) begin
      n_err++; $display("FAIL rr_first got=%b/%0d exp=1/1", grant_valid, grant_ch);
    end
    serve(1, 3, ok);
    n_vec++;
    if ({ok, busy, grant_valid, ack} !== {3'b100, 16'h0002}) begin
      n_err++; $display("FAIL rr_done got=%b%b%b/%h exp=100/0002", ok, busy, grant_valid, ack);
    end
    tick();
    n_vec++;
    if ({grant_valid, grant_ch, ack} !== {1'b1, 4'd5, 16'h0}) begin
      n_err++; $display("FAIL rr_turnaround got=%b/%0d/%h exp=1/5/0000", grant_valid, grant_ch, ack);
    end
    serve(2, 3, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL rr_serve got=timeout exp=2 grants"); end
  endtask

  task automatic test_requeue();
    bit ok;
    int seen;
    push(2, 1'b1); push(2, 1'b1);
    req[2] = 1'b1;
    repeat (2) tick();
    n_vec++;
    if ({grant_valid, grant_ch} !== {1'b1, 4'd2}) begin
      n_err++; $display("FAIL rq_offer got=%b/%0d exp=1/2", grant_valid, grant_ch);
    end
    tick();
    req[2] = 1'b0; tick();
    req[2] = 1'b1; tick();
    req[2] = 1'b0; tick();
    req[2] = 1'b1; tick();
    req[2] = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    serve(1, 3, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL rq_regrant got=timeout exp=1 grant"); end
    seen = 0;
    repeat (8) begin tick(); if (grant_valid !== 1'b0 || busy !== 1'b0) seen++; end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL rq_extra got=%0d exp=0", seen); end
  endtask

  task automatic test_watchdog();
    int bad;
    timeout = 16'd5;
    push(7, 1'b0);
    req[7] = 1'b1; tick(); req[7] = 1'b0; tick(); tick();
    bad = 0;
    repeat (4) begin tick(); if ({timeout_err, busy} !== 2'b01) bad++; end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL wd_early got=%0d exp=0", bad); end
    tick();
    n_vec++;
    if ({timeout_err, busy, err_ch, ack} !== {2'b10, 4'd7, 16'h0}) begin
      n_err++; $display("FAIL wd_abort got=%b/%0d/%h exp=10/7/0000", {timeout_err, busy}, err_ch, ack);
    end
    tick();
    n_vec++;
    if ({timeout_err, err_ch} !== {1'b0, 4'd7}) begin
      n_err++; $display("FAIL wd_pulse got=%b/%0d exp=0/7", timeout_err, err_ch);
    end
    timeout = '0;
    push(7, 1'b1);
    req[7] = 1'b1; tick(); req[7] = 1'b0; tick(); tick();
    bad = 0;
    repeat (40) begin tick(); if ({timeout_err, busy} !== 2'b01) bad++; end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL wd_disabled got=%0d exp=0", bad); end
    done = 1'b1; tick(); done = 1'b0;
    n_vec++;
    if (ack !== 16'h0080) begin n_err++; $display("FAIL wd_done got=%h exp=0080", ack); end
  endtask

  task automatic test_collision();
    timeout = 16'd4;
    push(9, 1'b1);
    req[9] = 1'b1; tick(); req[9] = 1'b0; tick(); tick();
    repeat (3) tick();
    done = 1'b1; tick(); done = 1'b0;
    n_vec++;
    if ({ack, timeout_err, err_ch} !== {16'h0200, 1'b0, 4'd7}) begin
      n_err++; $display("FAIL collide got=%h/%b/%0d exp=0200/0/7", ack, timeout_err, err_ch);
    end
    tick();
    n_vec++;
    if ({timeout_err, busy} !== 2'b00) begin n_err++; $display("FAIL collide_after got=%b exp=00", {timeout_err, busy}); end
    done = 1'b1; tick(); done = 1'b0; tick();
    n_vec++;
    if ({ack, busy} !== 17'h0) begin n_err++; $display("FAIL stray_done got=%h/%b exp=0000/0", ack, busy); end
    timeout = '0;
  endtask

  task automatic test_backpressure();
    int bad;
    grant_ready = 1'b0;
    push(4, 1'b1);
    req[4] = 1'b1; req[6] = 1'b1; req[8] = 1'b1;
    repeat (2) tick();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin ch_enable[4] = 1'b0; ch_enable[6] = 1'b0; ch_enable[8] = 1'b0; end
      if ({grant_valid, grant_ch} !== {1'b1, 4'd4}) bad++;
      tick();
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL bp_stable got=%0d exp=0", bad); end
    grant_ready = 1'b1;
    tick();
    n_vec++;
    if ({busy, grant_valid} !== 2'b10) begin n_err++; $display("FAIL bp_accept got=%b exp=10", {busy, grant_valid}); end
    repeat (2) tick();
    done = 1'b1; tick(); done = 1'b0;
    n_vec++;
    if (ack !== 16'h0010) begin n_err++; $display("FAIL bp_ack got=%h exp=0010", ack); end
    ch_enable = '1;
    bad = 0;
    repeat (10) begin tick(); if (grant_valid !== 1'b0) bad++; end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL bp_disabled got=%0d exp=0", bad); end
    req = '0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_round_robin();
    test_requeue();
    test_watchdog();
    test_collision();
    test_backpressure();
    repeat (2) tick();
    n_vec++;
    if (exp_grant.size() != 0 || exp_ack.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got=%0d/%0d exp=0/0", exp_grant.size(), exp_ack.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
